rf_wb_scheduler: RTL

//  Schedules the regfile's single write port between two writeback requesters: req0 = EXU ALU result, req1 = LSU load return.

---
 rtl/rf_wb_scheduler.sv | 109 ++++++++++
 1 files changed

// File: rtl/rf_wb_scheduler.sv
// Round-robin writeback scheduler for the single regfile write port, with a pending-write scoreboard.
// Optional RF_WB_BYPASS_EN forwards the registered write data to IDU source operands.
module rf_wb_scheduler #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              wena_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              fwd1_valid_o,
    output logic [DATA_W-1:0] fwd1_data_o,
    output logic              fwd2_valid_o,
    output logic [DATA_W-1:0] fwd2_data_o
);

    // rr_ptr == 0 means req0 wins a tie; it flips only when both ask.
    logic              rr_ptr;
    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              sb1;
    logic              sb2;

    assign grant0 = req0_valid_i && (!req1_valid_i || !rr_ptr);
    assign grant1 = req1_valid_i && (!req0_valid_i || rr_ptr);
    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign win_addr = grant1 ? req1_addr_i : req0_addr_i;
    assign win_data = grant1 ? req1_data_i : req0_data_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= 1'b0;
            wena_o  <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            wena_o <= (grant0 || grant1) && (win_addr != '0);
            if (grant0 || grant1) begin
                waddr_o <= win_addr;
                wdata_o <= win_data;
            end
            if (req0_valid_i && req1_valid_i)
                rr_ptr <= ~rr_ptr;
        end
    end

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wena_o)
            busy_next[waddr_o] = 1'b0;
        if (issue_valid_i && (issue_rd_i != '0))
            busy_next[issue_rd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign sb1 = busy[rs1_i];
    assign sb2 = busy[rs2_i];

`ifdef RF_WB_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1         = wena_o && (waddr_o == rs1_i) && (rs1_i != '0);
    assign hit2         = wena_o && (waddr_o == rs2_i) && (rs2_i != '0);
    assign rs1_busy_o   = sb1 && !hit1;
    assign rs2_busy_o   = sb2 && !hit2;
    assign fwd1_valid_o = hit1;
    assign fwd2_valid_o = hit2;
    assign fwd1_data_o  = hit1 ? wdata_o : '0;
    assign fwd2_data_o  = hit2 ? wdata_o : '0;
`else
    assign rs1_busy_o   = sb1;
    assign rs2_busy_o   = sb2;
    assign fwd1_valid_o = 1'b0;
    assign fwd2_valid_o = 1'b0;
    assign fwd1_data_o  = '0;
    assign fwd2_data_o  = '0;
`endif

endmodule
